// File: rtl/inst_encoder.sv
// inst_encoder: packs symbolic instructions into 32-bit words, buffers them
// in a small FIFO and writes them to instruction memory at consecutive word
// addresses from a programmable base.
// Optional feature macro: INST_ENC_BRANCH_PAD_EN (one NOP pad word after each
// accepted BEZ/BNE/JMP).
module inst_encoder #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        op,
  input  logic [4:0]        dst,
  input  logic [4:0]        src1,
  input  logic [4:0]        src2,
  input  logic [15:0]       imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] word_cnt,
  output logic [7:0]        err_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN} state_e;

  state_e            state_q, state_d;
  logic [31:0]       fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic        pop, push, push_word, pad_push, accept;
  logic        fifo_room, pad_pending, drain_empty;
  logic [31:0] push_data;
  logic        unused_base_bits;

  // The low address bits are forced to zero; the inputs are intentionally dropped.
  assign unused_base_bits = ^base_addr[1:0];

  // Encode the presented instruction and classify its opcode.
  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b0;
    case (op)
      6'b000001, 6'b000011, 6'b000101, 6'b000110, 6'b000111,
      6'b001000, 6'b001001, 6'b001010, 6'b001011, 6'b001100: begin
        enc_word  = {op, dst, src1, src2, 11'b0};
        enc_legal = 1'b1;
      end
      6'b100000, 6'b100001, 6'b100100: begin
        enc_word  = {op, dst, src1, imm};
        enc_legal = 1'b1;
      end
      6'b100101, 6'b101001: begin
        // ST and BNE carry src2 in the A field
        enc_word  = {op, src2, src1, imm};
        enc_legal = 1'b1;
      end
      6'b101000: begin
        enc_word  = {op, 5'b0, src1, imm};
        enc_legal = 1'b1;
      end
      6'b101010: begin
        enc_word  = {op, 10'b0, imm};
        enc_legal = 1'b1;
      end
      default: begin
        enc_word  = 32'h0;
        enc_legal = 1'b0;
      end
    endcase
  end

  // A popped word frees its slot on the same edge, so a full FIFO can still take a push.
  assign pop         = mem_we && mem_ready;
  assign fifo_room   = (count_q != DEPTH_C) || pop;
  assign accept      = in_valid && in_ready;
  assign push_word   = accept && enc_legal;
  assign pad_push    = pad_pending && fifo_room;
  assign push        = push_word || pad_push;
  assign push_data   = pad_push ? 32'h0 : enc_word;
  assign drain_empty = (count_q == '0) && !pad_pending;

`ifdef INST_ENC_BRANCH_PAD_EN
  logic enc_branch;
  logic pad_pending_q, pad_pending_d;

  assign enc_branch = (op == 6'b101000) || (op == 6'b101001) || (op == 6'b101010);

  // A pad becomes pending on an accepted branch and clears once the NOP is pushed.
  always_comb begin
    pad_pending_d = pad_pending_q;
    if (pad_push)
      pad_pending_d = 1'b0;
    else if (push_word && enc_branch)
      pad_pending_d = 1'b1;
  end

  // Pad-pending register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pad_pending_q <= 1'b0;
    else      pad_pending_q <= pad_pending_d;
  end

  assign pad_pending = pad_pending_q;
`else
  assign pad_pending = 1'b0;
`endif

  // FIFO storage; contents need no reset because the count gates every read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= push_data;
  end

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Session counters: start reloads them, each write advances address and count.
  always_comb begin
    mem_addr_d = mem_addr_q;
    word_cnt_d = word_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (state_q == S_IDLE && start) begin
      mem_addr_d = {base_addr[ADDR_W-1:2], 2'b00};
      word_cnt_d = '0;
      err_cnt_d  = '0;
    end else begin
      if (pop) begin
        mem_addr_d = mem_addr_q + ADDR_W'(4);
        word_cnt_d = word_cnt_q + ADDR_W'(1);
      end
      if (accept && !enc_legal && err_cnt_q != 8'hFF)
        err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      mem_addr_q <= '0;
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mem_addr_q <= mem_addr_d;
      word_cnt_q <= word_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)       state_d = S_LOAD;
      S_LOAD:  if (finish)      state_d = S_DRAIN;
      S_DRAIN: if (drain_empty) state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DRAIN) && drain_empty;
    in_ready = (state_q == S_LOAD) && fifo_room && !pad_pending;
  end

  assign mem_we    = (count_q != '0);
  assign mem_wdata = mem_we ? fifo_mem[rd_ptr_q] : 32'h0;
  assign mem_addr  = mem_addr_q;
  assign word_cnt  = word_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed instructions, scoreboard of expected
// memory writes checked by an independent monitor.
module tb_inst_encoder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, finish, in_valid, in_ready;
  logic [9:0]  base_addr;
  logic [5:0]  op;
  logic [4:0]  dst, src1, src2;
  logic [15:0] imm;
  logic        mem_we, mem_ready, busy, done;
  logic [9:0]  mem_addr, word_cnt;
  logic [31:0] mem_wdata;
  logic [7:0]  err_cnt;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [9:0] exp_addr;
  int         tests  = 0;
  int         failed = 0;

`ifdef INST_ENC_BRANCH_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  inst_encoder #(.ADDR_W(10), .DEPTH(4)) dut (
    .clk(clk), .rst(rst_n), .start(start), .base_addr(base_addr),
    .finish(finish), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .dst(dst), .src1(src1), .src2(src2), .imm(imm),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .word_cnt(word_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] w);
    exp_q.push_back('{exp_addr, w});
    exp_addr = exp_addr + 10'd4;
  endtask

  // Monitor: every accepted memory write is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && mem_we && mem_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL unexpected_write: got addr %h data %h, expected none", mem_addr, mem_wdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data) begin
          failed++;
          $display("FAIL write: got addr %h data %h expected addr %h data %h",
                   mem_addr, mem_wdata, e.addr, e.data);
        end else
          $display("[TB] write addr %h data %h", mem_addr, mem_wdata);
      end
    end
  end

  // All stimulus tasks start and end at posedge+1.
  task automatic pulse_start(input logic [9:0] base);
    start = 1'b1; base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
    exp_addr = base & 10'h3FC;
  endtask

  task automatic pulse_finish();
    finish = 1'b1;
    @(posedge clk); #1;
    finish = 1'b0;
  endtask

  task automatic set_ins(input logic [5:0] o, input logic [4:0] d, input logic [4:0] a,
                         input logic [4:0] b, input logic [15:0] im);
    op = o; dst = d; src1 = a; src2 = b; imm = im;
  endtask

  task automatic send(input logic [5:0] o, input logic [4:0] d, input logic [4:0] a,
                      input logic [4:0] b, input logic [15:0] im,
                      input logic [31:0] w, input bit legal);
    bit acc = 1'b0;
    int n = 0;
    set_ins(o, d, a, b, im);
    in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      tests++; failed++;
      $display("FAIL accept_timeout: got no handshake for op %b, expected one", o);
    end else begin
      $display("[TB] accepted op %b word %h legal %0d", o, w, legal);
      if (legal) push_exp(w);
      if (legal && PAD && (o == 6'b101000 || o == 6'b101001 || o == 6'b101010))
        push_exp(32'h0);
    end
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    int n = 0;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = (exp_q.size() == 0) && !mem_we;
      n++;
    end
    chk("drain_complete", ok, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input logic [9:0] exp_wc);
    bit seen = 1'b0;
    bit busy_ok = 1'b1;
    int n = 0;
    while (!seen && n < 200) begin
      @(negedge clk);
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        seen = 1'b1;
        chk("done_word_cnt", word_cnt, exp_wc);
      end
      n++;
    end
    chk("done_seen", seen, 1);
    chk("busy_until_done", busy_ok, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
    @(posedge clk); #1;
    $display("[TB] session done word_cnt %0d", word_cnt);
  endtask

  logic [31:0] bp_word [6];
  logic [5:0]  bp_op   [6];
  logic [4:0]  bp_d    [6];
  logic [4:0]  bp_a    [6];
  logic [4:0]  bp_b    [6];
  logic [15:0] bp_imm  [6];

  initial begin
    bit          stable;
    int          accepted, idx;
    logic        s_we;
    logic [9:0]  s_addr;
    logic [31:0] s_data;

    // SUB, AND, OR, XOR, LD, ST
    bp_op = '{6'b000011, 6'b000101, 6'b000110, 6'b001000, 6'b100100, 6'b100101};
    bp_d  = '{5'd5, 5'd8, 5'd1, 5'd31, 5'd2, 5'd0};
    bp_a  = '{5'd6, 5'd9, 5'd1, 5'd0, 5'd3, 5'd5};
    bp_b  = '{5'd7, 5'd10, 5'd1, 5'd0, 5'd0, 5'd4};
    bp_imm = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h1234, 16'h0008};
    bp_word = '{32'h0CA63800, 32'h15095000, 32'h18210800, 32'h23E00000,
                32'h90431234, 32'h94850008};

    rst_n = 1'b0; start = 0; finish = 0; in_valid = 0; base_addr = '0;
    op = '0; dst = '0; src1 = '0; src2 = '0; imm = '0; mem_ready = 1'b1;
    exp_addr = '0;
    #3;
    chk("rst_mem_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    #20;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Session 1: single ADD at 0x040
    pulse_start(10'h040);
    send(6'b000001, 5'd1, 5'd2, 5'd3, 16'h0, 32'h04221800, 1);
    wait_drain();
    pulse_finish();
    wait_done(10'd1);

    // Session 2: immediates, branches, illegal opcode
    pulse_start(10'h000);
    send(6'b100000, 5'd4, 5'd0, 5'd0, 16'h0010, 32'h80800010, 1);
    send(6'b101010, 5'd0, 5'd0, 5'd0, 16'h0008, 32'hA8000008, 1);
    send(6'b101001, 5'd0, 5'd1, 5'd2, 16'hFFFE, 32'hA441FFFE, 1);
    send(6'b000010, 5'd1, 5'd1, 5'd1, 16'h1111, 32'h0, 0);
    @(negedge clk);
    chk("illegal_err_cnt", err_cnt, 1);
    chk("illegal_in_ready", in_ready, 1);
    @(posedge clk); #1;
    send(6'b101000, 5'd0, 5'd7, 5'd0, 16'h0020, 32'hA0070020, 1);
    wait_drain();
    pulse_finish();
    wait_done(PAD ? 10'd7 : 10'd4);

    // Session 3: backpressure, then finish with words still queued
    pulse_start(10'h100);
    @(negedge clk);
    chk("start_clears_err", err_cnt, 0);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    accepted = 0; idx = 0; stable = 1'b1;
    s_we = 0; s_addr = '0; s_data = '0;
    set_ins(bp_op[0], bp_d[0], bp_a[0], bp_b[0], bp_imm[0]);
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      bit acc;
      @(negedge clk);
      if (cyc == 1) begin
        s_we = mem_we; s_addr = mem_addr; s_data = mem_wdata;
      end else if (cyc > 1) begin
        if (mem_we !== s_we || mem_addr !== s_addr || mem_wdata !== s_data) stable = 1'b0;
      end
      acc = in_ready;
      @(posedge clk); #1;
      if (acc && idx < 6) begin
        push_exp(bp_word[idx]);
        $display("[TB] accepted op %b word %h under backpressure", bp_op[idx], bp_word[idx]);
        accepted++;
        idx++;
        if (idx < 6) set_ins(bp_op[idx], bp_d[idx], bp_a[idx], bp_b[idx], bp_imm[idx]);
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("bp_accepted", accepted, 4);
    chk("bp_held_we", s_we, 1);
    chk("bp_held_addr", s_addr, 10'h100);
    chk("bp_held_data", s_data, 32'h0CA63800);
    chk("bp_stable", stable, 1);
    @(negedge clk);
    chk("bp_full_in_ready", in_ready, 0);
    @(posedge clk); #1;
    mem_ready = 1'b1;
    wait_drain();
    mem_ready = 1'b0;
    send(bp_op[4], bp_d[4], bp_a[4], bp_b[4], bp_imm[4], bp_word[4], 1);
    send(bp_op[5], bp_d[5], bp_a[5], bp_b[5], bp_imm[5], bp_word[5], 1);
    send(bp_op[0], bp_d[0], bp_a[0], bp_b[0], bp_imm[0], bp_word[0], 1);
    pulse_finish();
    mem_ready = 1'b1;
    wait_done(10'd7);

    // Reset in the middle of a drain
    pulse_start(10'h080);
    mem_ready = 1'b0;
    send(6'b000001, 5'd1, 5'd2, 5'd3, 16'h0, 32'h04221800, 1);
    send(6'b000110, 5'd1, 5'd1, 5'd1, 16'h0, 32'h18210800, 1);
    send(6'b000010, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0, 0);
    pulse_finish();
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("mid_word_cnt", word_cnt, 1);
    chk("mid_err_cnt", err_cnt, 1);
    chk("mid_mem_we", mem_we, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_mem_we", mem_we, 0);
    chk("arst_word_cnt", word_cnt, 0);
    chk("arst_err_cnt", err_cnt, 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_busy", busy, 0);
    exp_q.delete();
    $display("[TB] reset asserted mid-drain");
    @(negedge clk) rst_n = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk); #1;

    // Session 4: unaligned base near the top, second write wraps to 0x000
    pulse_start(10'h3FF);
    send(6'b000001, 5'd1, 5'd2, 5'd3, 16'h0, 32'h04221800, 1);
    send(6'b000110, 5'd1, 5'd1, 5'd1, 16'h0, 32'h18210800, 1);
    pulse_finish();
    wait_done(10'd2);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
